pcie_skp_inserter: RTL and testbench

Transmit-side ordered-set insertion stage that sits directly upstream of the PCIe 8-bit scrambler. It accepts link-layer symbols over a valid/ready handshake and presents a continuous one-symbol-per-clock stream in the scrambler's input format (data, K flag, scramble-disable). It fills gaps with logical idle and periodically inserts a SKP ordered set (one COM followed by SKP_COUNT SKIP symbols), only between packets.

---
 rtl/pcie_skp_inserter.sv | 111 +++++++++++
 tb/tb_pcie_skp_inserter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pcie_skp_inserter.sv
// Transmit-side SKP ordered-set inserter in front of the 8-bit scrambler.
// Emits one symbol per clock: forwarded input, IDLE filler, or COM + SKIP run between packets.
module pcie_skp_inserter #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_COUNT    = 3,
  parameter logic [7:0]  COM          = 8'hBC,
  parameter logic [7:0]  SKIP         = 8'h1C,
  parameter logic [7:0]  IDLE         = 8'h00
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [7:0] in_data,
  input  logic       in_k,
  input  logic       in_dis_scrambler,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_k,
  output logic       out_dis_scrambler
);

  localparam int CW = $clog2(SKP_INTERVAL + 1);
  localparam int IW = (SKP_COUNT > 1) ? $clog2(SKP_COUNT) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(SKP_INTERVAL);
  localparam logic [IW-1:0] IDX_LAST = IW'(SKP_COUNT - 1);

  typedef enum logic {PASS, SKP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          pkt_q, pkt_d;
  logic [7:0]    data_q, data_d;
  logic          k_q, k_d;
  logic          dis_q, dis_d;
  logic          pending;
  logic          insert;
  logic          xfer;

  assign pending  = (cnt_q == CNT_MAX);
  assign insert   = pending && !pkt_q;
  // Ready never looks at in_valid, so upstream may wait on it combinationally.
  assign in_ready = (state_q == PASS) && !insert;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    data_d  = IDLE;
    k_d     = 1'b0;
    dis_d   = 1'b0;
    case (state_q)
      PASS: begin
        if (insert) begin
          data_d  = COM;
          k_d     = 1'b1;
          idx_d   = '0;
          state_d = SKP;
        end else begin
          // Saturate so a long packet just holds the request until it ends.
          if (!pending) cnt_d = cnt_q + CW'(1);
          if (xfer) begin
            data_d = in_data;
            k_d    = in_k;
            dis_d  = in_dis_scrambler;
            pkt_d  = !in_last;
          end
        end
      end
      SKP: begin
        data_d = SKIP;
        k_d    = 1'b1;
        idx_d  = idx_q + IW'(1);
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = PASS;
        end
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= PASS;
      cnt_q   <= '0;
      idx_q   <= '0;
      pkt_q   <= 1'b0;
      data_q  <= '0;
      k_q     <= 1'b0;
      dis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pkt_q   <= pkt_d;
      data_q  <= data_d;
      k_q     <= k_d;
      dis_q   <= dis_d;
    end
  end

  assign out_data          = data_q;
  assign out_k             = k_q;
  assign out_dis_scrambler = dis_q;

endmodule

// File: tb/tb_pcie_skp_inserter.sv
// Randomized bench for pcie_skp_inserter with a cycle-level reference model and
// an in-order symbol scoreboard that ignores filler and ordered sets.
module tb_pcie_skp_inserter;
  localparam int INTV = 8;
  localparam int CNT  = 3;
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] SKIP = 8'h1C;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [7:0] in_data;
  logic       in_k, in_dis_scrambler, in_last, in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_k, out_dis_scrambler;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int         m_cnt, m_os;
  bit         m_pkt, m_rdy;
  logic [7:0] m_d;
  bit         m_k, m_dis;

  logic [9:0] sent_q[$];
  int         com_at[$];
  int         cyc_n;

  pcie_skp_inserter #(.SKP_INTERVAL(INTV), .SKP_COUNT(CNT)) dut (
    .clk(clk), .rst_b(rst_b),
    .in_data(in_data), .in_k(in_k), .in_dis_scrambler(in_dis_scrambler),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_k(out_k), .out_dis_scrambler(out_dis_scrambler)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_os = 0; m_pkt = 0;
    m_d = 8'h00; m_k = 0; m_dis = 0;
    sent_q.delete();
    com_at.delete();
    cyc_n = 0;
  endtask

  // Spec rules: a SKP set is owed once INTV pass cycles have elapsed, and it
  // may only start outside a packet; it lasts 1 + CNT symbols.
  task automatic model_step(input bit xfer, input logic [7:0] d, input bit k,
                            input bit dis, input bit last);
    if (m_os > 0) begin
      m_d = SKIP; m_k = 1; m_dis = 0;
      m_os--;
      if (m_os == 0) m_cnt = 0;
    end else if (m_cnt >= INTV && !m_pkt) begin
      m_d = COM; m_k = 1; m_dis = 0;
      m_os = CNT;
    end else begin
      m_cnt++;
      if (xfer) begin
        m_d = d; m_k = k; m_dis = dis;
        m_pkt = !last;
      end else begin
        m_d = 8'h00; m_k = 0; m_dis = 0;
      end
    end
  endtask

  // One clock: inputs applied at negedge, outputs checked 1 time unit after posedge.
  task automatic cyc(input bit v, input logic [7:0] d, input bit k, input bit dis,
                     input bit last, output bit xfer);
    logic [9:0] exp_sym;
    in_valid = v; in_data = d; in_k = k; in_dis_scrambler = dis; in_last = last;
    #1;
    m_rdy = (m_os == 0) && !(m_cnt >= INTV && !m_pkt);
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    xfer = v && m_rdy;
    if (xfer) sent_q.push_back({d, k, dis});
    model_step(xfer, d, k, dis, last);
    @(posedge clk);
    #1;
    chk("out_data", 32'(out_data), 32'(m_d));
    chk("out_k", 32'(out_k), 32'(m_k));
    chk("out_dis", 32'(out_dis_scrambler), 32'(m_dis));
    if (out_k && out_data == COM) com_at.push_back(cyc_n);
    if (!(out_data == 8'h00 && !out_k && !out_dis_scrambler) &&
        !(out_k && (out_data == COM || out_data == SKIP))) begin
      if (sent_q.size() == 0) chk("sb_extra", 32'd1, 32'd0);
      else begin
        exp_sym = sent_q.pop_front();
        chk("sb_sym", 32'({out_data, out_k, out_dis_scrambler}), 32'(exp_sym));
      end
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit x;
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 0, x);
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic do_reset();
    rst_b = 1'b0;
    in_valid = 0;
    #1;
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_k", 32'(out_k), 32'h0);
    chk("rst_dis", 32'(out_dis_scrambler), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] start, input bit rnd,
                          input int gap_pct, output int stall0);
    int i, guard;
    bit x, have;
    logic [7:0] d;
    bit k, dis;
    i = 0; guard = 0; stall0 = 0; have = 0;
    d = 8'h00; k = 0; dis = 0;
    while (i < len && guard < len * 4 + 40) begin
      if (!have) begin
        if (rnd) begin
          d = 8'($urandom_range(255, 1));
          k = 1'($urandom_range(1));
          dis = 1'($urandom_range(1));
          if (k && (d == COM || d == SKIP)) d = d ^ 8'h01;
        end else begin
          d = start + 8'(i); k = 0; dis = 0;
        end
        have = 1;
      end
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        cyc(0, 8'h00, 0, 0, 0, x);
      end else begin
        cyc(1, d, k, dis, i == len - 1, x);
        if (x) begin i++; have = 0; end
        else if (i == 0) stall0++;
      end
      guard++;
    end
    if (i < len) chk("pkt_timeout", 32'(i), 32'(len));
  endtask

  initial begin
    int st;
    bit x;
    rst_b = 1'b0;
    in_valid = 0; in_data = 0; in_k = 0; in_dis_scrambler = 0; in_last = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_data", 32'(out_data), 32'h0);
    chk("init_k", 32'(out_k), 32'h0);
    chk("init_ready", 32'(in_ready), 32'h1);
    rst_b = 1'b1;

    // idle-only: COM at output index 8 and again 12 later
    idle(26);
    chk("idle_com0", com_at.size() > 0 ? 32'(com_at[0]) : 32'hFFFFFFFF, 32'd8);
    chk("idle_com1", com_at.size() > 1 ? 32'(com_at[1]) : 32'hFFFFFFFF, 32'd20);

    // long packet: 0x01..0x14 starting at cycle 2; COM follows 0x14 directly
    do_reset();
    idle(2);
    send_pkt(20, 8'h01, 0, 0, st);
    idle(6);
    chk("long_com", com_at.size() > 0 ? 32'(com_at[0]) : 32'hFFFFFFFF, 32'd22);

    // back-to-back packets straddling the interval boundary
    do_reset();
    send_pkt(8, 8'h30, 0, 0, st);
    send_pkt(4, 8'h40, 0, 0, st);
    chk("b2b_stall", 32'(st), 32'd4);
    idle(4);

    // flag pass-through
    do_reset();
    cyc(1, 8'hF7, 1, 0, 0, x);
    chk("pt_f7", 32'({out_data, out_k, out_dis_scrambler}), 32'({8'hF7, 1'b1, 1'b0}));
    cyc(1, 8'h5A, 0, 1, 1, x);
    chk("pt_5a", 32'({out_data, out_k, out_dis_scrambler}), 32'({8'h5A, 1'b0, 1'b1}));
    idle(3);

    // reset after COM + one SKIP; full interval and complete set afterwards
    do_reset();
    idle(10);
    chk("pre_rst_skip", 32'({out_data, out_k}), 32'({SKIP, 1'b1}));
    do_reset();
    idle(14);
    chk("post_rst_com", com_at.size() > 0 ? 32'(com_at[0]) : 32'hFFFFFFFF, 32'd8);

    // randomized traffic
    do_reset();
    for (int p = 0; p < 60; p++) begin
      send_pkt(int'($urandom_range(24, 1)), 8'h00, 1, 20, st);
      idle(int'($urandom_range(5)));
    end
    idle(16);
    chk("sb_empty", 32'(sent_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
